// File: rtl/ysyx_23060208_xbar.sv
// 1-master / 2-slave AXI-Lite read crossbar: LSU read port -> data SRAM or CLINT mtime, local DECERR otherwise.
// Latency: AR accepted in cycle N -> slave arvalid in N+1; R data passes through combinationally.
// Backpressure: one read outstanding; m_arready drops until the R handshake completes, slave ready/valid forwarded.
module ysyx_23060208_xbar #(
    parameter int                    DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] SRAM_BASE  = 32'h8000_0000,
    parameter logic [DATA_WIDTH-1:0] CLINT_BASE = 32'ha000_0048
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic [DATA_WIDTH-1:0] m_araddr,
    input  logic                  m_arvalid,
    output logic                  m_arready,
    output logic [DATA_WIDTH-1:0] m_rdata,
    output logic [1:0]            m_rresp,
    output logic                  m_rvalid,
    input  logic                  m_rready,

    output logic [DATA_WIDTH-1:0] sram_araddr,
    output logic                  sram_arvalid,
    input  logic                  sram_arready,
    input  logic [DATA_WIDTH-1:0] sram_rdata,
    input  logic [1:0]            sram_rresp,
    input  logic                  sram_rvalid,
    output logic                  sram_rready,

    output logic [DATA_WIDTH-1:0] clint_araddr,
    output logic                  clint_arvalid,
    input  logic                  clint_arready,
    input  logic [DATA_WIDTH-1:0] clint_rdata,
    input  logic [1:0]            clint_rresp,
    input  logic                  clint_rvalid,
    output logic                  clint_rready
);

    // Window sizes: 128 MiB of SRAM, two 32-bit mtime words in the CLINT.
    localparam logic [DATA_WIDTH-1:0] SRAM_SIZE  = DATA_WIDTH'(32'h0800_0000);
    localparam logic [DATA_WIDTH-1:0] CLINT_SIZE = DATA_WIDTH'(8);
    localparam logic [1:0]            RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FWD_AR = 2'd1,
        WAIT_R = 2'd2,
        ERR_R  = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        SEL_NONE  = 2'd0,
        SEL_SRAM  = 2'd1,
        SEL_CLINT = 2'd2
    } sel_t;

    state_t                  state;
    state_t                  state_nxt;
    sel_t                    sel;
    sel_t                    dec_sel;
    logic [DATA_WIDTH-1:0]   addr;
    logic [DATA_WIDTH-1:0]   sram_off;
    logic [DATA_WIDTH-1:0]   clint_off;
    logic                    hit_sram;
    logic                    hit_clint;
    logic                    ar_fire;

    // Offsets wrap below the base, so a single unsigned compare covers both window edges.
    assign sram_off  = m_araddr - SRAM_BASE;
    assign clint_off = m_araddr - CLINT_BASE;
    assign hit_sram  = (sram_off < SRAM_SIZE);
    assign hit_clint = (clint_off < CLINT_SIZE);

    // Address decode of the incoming request; CLINT wins if the windows are ever configured to overlap.
    always_comb begin
        dec_sel = SEL_NONE;
        if (hit_clint) begin
            dec_sel = SEL_CLINT;
        end else if (hit_sram) begin
            dec_sel = SEL_SRAM;
        end
    end

    // Accepting only in IDLE keeps exactly one read in flight.
    assign ar_fire = m_arvalid && m_arready;

    // Both slave address ports mirror the latched request; only arvalid distinguishes the target.
    assign sram_araddr  = addr;
    assign clint_araddr = addr;

    // State register plus the request latch (address and decoded target).
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            addr  <= '0;
            sel   <= SEL_NONE;
        end else begin
            state <= state_nxt;
            if (ar_fire) begin
                addr <= m_araddr;
                sel  <= dec_sel;
            end
        end
    end

    // Next-state and handshake routing; unselected slave and idle master outputs stay at zero.
    always_comb begin
        state_nxt     = state;
        m_arready     = 1'b0;
        m_rvalid      = 1'b0;
        m_rdata       = '0;
        m_rresp       = 2'b00;
        sram_arvalid  = 1'b0;
        sram_rready   = 1'b0;
        clint_arvalid = 1'b0;
        clint_rready  = 1'b0;

        unique case (state)
            IDLE: begin
                m_arready = !rst;
                if (m_arvalid && !rst) begin
                    state_nxt = (dec_sel == SEL_NONE) ? ERR_R : FWD_AR;
                end
            end

            FWD_AR: begin
                unique case (sel)
                    SEL_SRAM: begin
                        sram_arvalid = 1'b1;
                        if (sram_arready) begin
                            state_nxt = WAIT_R;
                        end
                    end
                    SEL_CLINT: begin
                        clint_arvalid = 1'b1;
                        if (clint_arready) begin
                            state_nxt = WAIT_R;
                        end
                    end
                    default: begin
                        // Unmapped requests never reach this state; answer with an error rather than hang.
                        state_nxt = ERR_R;
                    end
                endcase
            end

            WAIT_R: begin
                unique case (sel)
                    SEL_SRAM: begin
                        m_rvalid    = sram_rvalid;
                        m_rdata     = sram_rdata;
                        m_rresp     = sram_rresp;
                        sram_rready = m_rready;
                        if (sram_rvalid && m_rready) begin
                            state_nxt = IDLE;
                        end
                    end
                    SEL_CLINT: begin
                        m_rvalid     = clint_rvalid;
                        m_rdata      = clint_rdata;
                        m_rresp      = clint_rresp;
                        clint_rready = m_rready;
                        if (clint_rvalid && m_rready) begin
                            state_nxt = IDLE;
                        end
                    end
                    default: begin
                        state_nxt = ERR_R;
                    end
                endcase
            end

            ERR_R: begin
                m_rvalid = 1'b1;
                m_rresp  = RESP_DECERR;
                if (m_rready) begin
                    state_nxt = IDLE;
                end
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_ysyx_23060208_xbar.sv
// Self-checking bench for the read crossbar: directed cases, reset abort, then randomized reads.
// Expected routing/data come from address-window arithmetic and the data the bench's slaves return.
// Slaves are driven step by step with programmable AR/R stalls and spurious rvalid noise.
module tb_ysyx_23060208_xbar;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] m_araddr;
    logic        m_arvalid;
    logic        m_arready;
    logic [31:0] m_rdata;
    logic [1:0]  m_rresp;
    logic        m_rvalid;
    logic        m_rready;
    logic [31:0] sram_araddr;
    logic        sram_arvalid;
    logic        sram_arready;
    logic [31:0] sram_rdata;
    logic [1:0]  sram_rresp;
    logic        sram_rvalid;
    logic        sram_rready;
    logic [31:0] clint_araddr;
    logic        clint_arvalid;
    logic        clint_arready;
    logic [31:0] clint_rdata;
    logic [1:0]  clint_rresp;
    logic        clint_rvalid;
    logic        clint_rready;

    int checks = 0;
    int errors = 0;
    int sram_ar_cnt = 0, clint_ar_cnt = 0, m_r_cnt = 0;
    int exp_sram_ar = 0, exp_clint_ar = 0, exp_m_r = 0;

    always #5 clk = ~clk;

    ysyx_23060208_xbar dut (
        .clk(clk), .rst(rst),
        .m_araddr(m_araddr), .m_arvalid(m_arvalid), .m_arready(m_arready),
        .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rvalid(m_rvalid), .m_rready(m_rready),
        .sram_araddr(sram_araddr), .sram_arvalid(sram_arvalid), .sram_arready(sram_arready),
        .sram_rdata(sram_rdata), .sram_rresp(sram_rresp), .sram_rvalid(sram_rvalid),
        .sram_rready(sram_rready),
        .clint_araddr(clint_araddr), .clint_arvalid(clint_arvalid), .clint_arready(clint_arready),
        .clint_rdata(clint_rdata), .clint_rresp(clint_rresp), .clint_rvalid(clint_rvalid),
        .clint_rready(clint_rready)
    );

    // Handshake counters, used to prove no transfer is lost or duplicated.
    always @(posedge clk) begin
        if (!rst) begin
            if (sram_arvalid && sram_arready)   sram_ar_cnt  <= sram_ar_cnt + 1;
            if (clint_arvalid && clint_arready) clint_ar_cnt <= clint_ar_cnt + 1;
            if (m_rvalid && m_rready)           m_r_cnt      <= m_r_cnt + 1;
        end
    end

    // Reference address map: 0 = unmapped, 1 = SRAM, 2 = CLINT.
    function automatic int route(input logic [31:0] a);
        if (a >= 32'ha000_0048 && a < 32'ha000_0050) return 2;
        if (a >= 32'h8000_0000 && a < 32'h8800_0000) return 1;
        return 0;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic slaves_idle();
        sram_arready = 1'b0; sram_rvalid = 1'b0; sram_rdata = '0; sram_rresp = 2'b00;
        clint_arready = 1'b0; clint_rvalid = 1'b0; clint_rdata = '0; clint_rresp = 2'b00;
    endtask

    // One complete read. Ends right after the posedge carrying the R handshake.
    task automatic txn(input logic [31:0] a, input int arw, input int rw, input int rrw,
                       input logic [31:0] d, input logic [1:0] resp, input bit keep);
        int  r;
        bit  cl;
        r  = route(a);
        cl = (r == 2);
        @(negedge clk);
        slaves_idle();
        m_araddr = a; m_arvalid = 1'b1; m_rready = 1'b0;
        #1;
        chk("idle_arready", m_arready, 1);
        chk("idle_rvalid", m_rvalid, 0);
        chk("idle_sram_arvalid", sram_arvalid, 0);
        chk("idle_clint_arvalid", clint_arvalid, 0);
        @(posedge clk);
        @(negedge clk);
        m_arvalid = keep;
        m_araddr  = $urandom;
        if (r == 0) begin
            sram_rvalid = 1'b1; sram_rdata = $urandom; clint_rvalid = 1'b1; clint_rdata = $urandom;
            for (int i = 0; i <= rrw; i++) begin
                if (i > 0) @(negedge clk);
                m_rready = (i == rrw);
                #1;
                chk("err_rvalid", m_rvalid, 1);
                chk("err_rdata", m_rdata, 0);
                chk("err_rresp", m_rresp, 3);
                chk("err_sram_arvalid", sram_arvalid, 0);
                chk("err_clint_arvalid", clint_arvalid, 0);
                chk("err_arready", m_arready, 0);
                chk("err_slave_rready", {sram_rready, clint_rready}, 0);
                @(posedge clk);
            end
            exp_m_r++;
        end else begin
            for (int i = 0; i <= arw; i++) begin
                if (i > 0) @(negedge clk);
                sram_rvalid = 1'b1; sram_rdata = $urandom; clint_rvalid = 1'b1; clint_rdata = $urandom;
                if (cl) clint_arready = (i == arw); else sram_arready = (i == arw);
                #1;
                chk("fwd_sram_arvalid", sram_arvalid, !cl);
                chk("fwd_clint_arvalid", clint_arvalid, cl);
                chk("fwd_sram_araddr", sram_araddr, a);
                chk("fwd_clint_araddr", clint_araddr, a);
                chk("fwd_arready", m_arready, 0);
                chk("fwd_rvalid", m_rvalid, 0);
                chk("fwd_rdata", m_rdata, 0);
                @(posedge clk);
            end
            if (cl) exp_clint_ar++; else exp_sram_ar++;
            @(negedge clk);
            slaves_idle();
            for (int i = 0; i < rw; i++) begin
                #1;
                chk("wr_gap_rvalid", m_rvalid, 0);
                chk("wr_gap_arvalid", {sram_arvalid, clint_arvalid}, 0);
                @(posedge clk);
                @(negedge clk);
            end
            if (cl) begin
                clint_rvalid = 1'b1; clint_rdata = d; clint_rresp = resp;
                sram_rvalid = 1'b1; sram_rdata = ~d; sram_rresp = 2'b10;
            end else begin
                sram_rvalid = 1'b1; sram_rdata = d; sram_rresp = resp;
                clint_rvalid = 1'b1; clint_rdata = ~d; clint_rresp = 2'b10;
            end
            for (int i = 0; i <= rrw; i++) begin
                if (i > 0) @(negedge clk);
                m_rready = (i == rrw);
                #1;
                chk("wr_rvalid", m_rvalid, 1);
                chk("wr_rdata", m_rdata, d);
                chk("wr_rresp", m_rresp, resp);
                chk("wr_tgt_rready", cl ? clint_rready : sram_rready, m_rready);
                chk("wr_oth_rready", cl ? sram_rready : clint_rready, 0);
                chk("wr_arready", m_arready, 0);
                @(posedge clk);
            end
            exp_m_r++;
        end
    endtask

    initial begin
        logic [31:0] a;
        int          k;
        rst = 1'b1; m_araddr = '0; m_arvalid = 1'b0; m_rready = 1'b0;
        slaves_idle();
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        chk("rst_arready", m_arready, 0);
        chk("rst_rvalid", m_rvalid, 0);
        chk("rst_rdata", m_rdata, 0);
        chk("rst_rresp", m_rresp, 0);
        chk("rst_arvalids", {sram_arvalid, clint_arvalid}, 0);
        chk("rst_rreadys", {sram_rready, clint_rready}, 0);
        chk("rst_sram_araddr", sram_araddr, 0);
        chk("rst_clint_araddr", clint_araddr, 0);
        rst = 1'b0;
        #1;
        chk("post_rst_arready", m_arready, 1);

        // Directed cases from the block's intended use.
        txn(32'h8000_0010, 0, 2, 0, 32'hdeadbeef, 2'b00, 0);
        txn(32'ha000_0048, 0, 0, 0, 32'h0000_0001, 2'b00, 0);
        txn(32'ha000_004c, 1, 1, 1, 32'h0000_0007, 2'b00, 0);
        txn(32'ha000_0050, 0, 0, 0, 32'h0, 2'b00, 0);
        txn(32'h1000_0000, 0, 0, 3, 32'h0, 2'b00, 0);
        txn(32'h8000_0100, 3, 1, 2, 32'hcafe_f00d, 2'b00, 0);
        txn(32'h87ff_fffc, 0, 0, 0, 32'h1357_9bdf, 2'b10, 0);
        txn(32'h8800_0000, 0, 0, 1, 32'h0, 2'b00, 0);
        txn(32'h7fff_fffc, 0, 0, 0, 32'h0, 2'b00, 0);
        txn(32'ha000_0044, 0, 0, 0, 32'h0, 2'b00, 0);

        // Reset while waiting for R: everything drops, then a normal read follows.
        @(negedge clk);
        slaves_idle();
        m_araddr = 32'h8000_0200; m_arvalid = 1'b1; m_rready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        m_arvalid = 1'b0; sram_arready = 1'b1;
        #1;
        chk("rstmid_sram_arvalid", sram_arvalid, 1);
        @(posedge clk);
        exp_sram_ar++;
        @(negedge clk);
        sram_arready = 1'b0; sram_rvalid = 1'b1; sram_rdata = 32'h1234_5678;
        #1;
        chk("rstmid_rvalid_before", m_rvalid, 1);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        #1;
        chk("rstmid_rvalid", m_rvalid, 0);
        chk("rstmid_arvalids", {sram_arvalid, clint_arvalid}, 0);
        chk("rstmid_sram_rready", sram_rready, 0);
        chk("rstmid_arready_in_rst", m_arready, 0);
        rst = 1'b0;
        #1;
        chk("rstmid_arready_after", m_arready, 1);
        chk("rstmid_rvalid_after", m_rvalid, 0);
        txn(32'h8000_0300, 0, 0, 0, 32'h0bad_cafe, 2'b00, 0);

        // Back-to-back alternating SRAM/CLINT with m_arvalid held high throughout.
        for (int i = 0; i < 8; i++) begin
            if (i % 2 == 0) a = 32'h8000_0000 + ($urandom_range(0, 32'h01ff_ffff) << 2);
            else            a = 32'ha000_0048 + (($urandom_range(0, 1)) << 2);
            txn(a, 0, 0, 0, $urandom, 2'b00, 1);
        end

        // Randomized mix of targets, stalls and responses.
        for (int i = 0; i < 60; i++) begin
            k = $urandom_range(0, 3);
            if (k == 0)      a = 32'h8000_0000 + ($urandom_range(0, 32'h01ff_ffff) << 2);
            else if (k == 1) a = 32'ha000_0048 + (($urandom_range(0, 1)) << 2);
            else if (k == 2) a = $urandom;
            else             a = 32'ha000_0040 + ($urandom_range(0, 7) << 2);
            txn(a, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                $urandom, ($urandom_range(0, 1) != 0) ? 2'b10 : 2'b00, $urandom_range(0, 1) != 0);
        end

        @(negedge clk);
        m_arvalid = 1'b0; m_rready = 1'b0;
        slaves_idle();
        #1;
        chk("end_idle_arready", m_arready, 1);
        chk("end_idle_rvalid", m_rvalid, 0);
        @(posedge clk);
        @(negedge clk);
        chk("cnt_sram_ar", sram_ar_cnt, exp_sram_ar);
        chk("cnt_clint_ar", clint_ar_cnt, exp_clint_ar);
        chk("cnt_m_r", m_r_cnt, exp_m_r);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
